// File: rtl/i2c_target_responder_if.sv
// Bus-side and register-file-side signals of the I2C target responder.
// The slave modport is the responder's view; master is the controller/user-logic side.
interface i2c_target_responder_if;
   logic       sclIn;
   logic       sdaIn;
   logic       sdaOut;
   logic [7:0] regAddr;
   logic [7:0] regWrData;
   logic       regWrEn;
   logic [7:0] regRdData;
   logic       regRdEn;
   logic       busy;

   modport slave (
      input  sclIn,
      input  sdaIn,
      input  regRdData,
      output sdaOut,
      output regAddr,
      output regWrData,
      output regWrEn,
      output regRdEn,
      output busy
   );

   modport master (
      output sclIn,
      output sdaIn,
      output regRdData,
      input  sdaOut,
      input  regAddr,
      input  regWrData,
      input  regWrEn,
      input  regRdEn,
      input  busy
   );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target with 7-bit device address and an 8-bit auto-incrementing register pointer.
// SCL/SDA are oversampled by clockIn; all outputs are registered.
module i2c_target_responder #(
   parameter logic [6:0]  SLAVE_ADDRESS = 7'h3C,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input logic                   clockIn,
   input logic                   reset_n,
   i2c_target_responder_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR     = 4'd1,
      ADDR_ACK = 4'd2,
      REG      = 4'd3,
      REG_ACK  = 4'd4,
      WR       = 4'd5,
      WR_ACK   = 4'd6,
      RD       = 4'd7,
      RD_ACK   = 4'd8,
      IGNORE   = 4'd9
   } state_t;

   logic [SYNC_STAGES-1:0] sclSync_r;
   logic [SYNC_STAGES-1:0] sdaSync_r;
   logic                   sclPrev_r;
   logic                   sdaPrev_r;

   logic sclNow_s;
   logic sdaNow_s;
   logic sclRise_s;
   logic sclFall_s;
   logic startDet_s;
   logic stopDet_s;

   state_t     state_r,     stateNext_s;
   logic [2:0] bitCnt_r,    bitCntNext_s;
   logic [6:0] rxShift_r,   rxShiftNext_s;
   logic [6:0] txShift_r,   txShiftNext_s;
   logic       ackPhase_r,  ackPhaseNext_s;
   logic       rw_r,        rwNext_s;
   logic       sdaOut_r,    sdaOutNext_s;
   logic [7:0] regAddr_r,   regAddrNext_s;
   logic [7:0] regWrData_r, regWrDataNext_s;
   logic       regWrEn_r,   regWrEnNext_s;
   logic       regRdEn_r,   regRdEnNext_s;
   logic       busy_r,      busyNext_s;
   logic [7:0] rxByte_s;

   // Synchroniser chains plus one-cycle history for edge detection
   always_ff @(posedge clockIn) begin
      if (!reset_n) begin
         sclSync_r <= {SYNC_STAGES{1'b1}};
         sdaSync_r <= {SYNC_STAGES{1'b1}};
         sclPrev_r <= 1'b1;
         sdaPrev_r <= 1'b1;
      end else begin
         sclSync_r <= {sclSync_r[SYNC_STAGES-2:0], bus.sclIn};
         sdaSync_r <= {sdaSync_r[SYNC_STAGES-2:0], bus.sdaIn};
         sclPrev_r <= sclSync_r[SYNC_STAGES-1];
         sdaPrev_r <= sdaSync_r[SYNC_STAGES-1];
      end
   end

   assign sclNow_s   = sclSync_r[SYNC_STAGES-1];
   assign sdaNow_s   = sdaSync_r[SYNC_STAGES-1];
   assign sclRise_s  = sclNow_s & ~sclPrev_r;
   assign sclFall_s  = ~sclNow_s & sclPrev_r;
   // SCL must be high on both samples so an SCL edge never masquerades as START/STOP
   assign startDet_s = sclNow_s & sclPrev_r & sdaPrev_r & ~sdaNow_s;
   assign stopDet_s  = sclNow_s & sclPrev_r & ~sdaPrev_r & sdaNow_s;
   assign rxByte_s   = {rxShift_r, sdaNow_s};

   // Next-state and next-output logic for the transaction FSM
   always_comb begin
      stateNext_s     = state_r;
      bitCntNext_s    = bitCnt_r;
      rxShiftNext_s   = rxShift_r;
      txShiftNext_s   = txShift_r;
      ackPhaseNext_s  = ackPhase_r;
      rwNext_s        = rw_r;
      sdaOutNext_s    = sdaOut_r;
      regAddrNext_s   = regAddr_r;
      regWrDataNext_s = regWrData_r;
      regWrEnNext_s   = 1'b0;
      regRdEnNext_s   = 1'b0;
      busyNext_s      = busy_r;

      if (startDet_s) begin
         stateNext_s    = ADDR;
         bitCntNext_s   = 3'd0;
         ackPhaseNext_s = 1'b0;
         sdaOutNext_s   = 1'b1;
      end else if (stopDet_s) begin
         stateNext_s  = IDLE;
         sdaOutNext_s = 1'b1;
         busyNext_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE, IGNORE: begin
               stateNext_s = state_r;
            end
            ADDR, REG, WR: begin
               if (sclRise_s) begin
                  rxShiftNext_s = rxByte_s[6:0];
                  bitCntNext_s  = bitCnt_r + 3'd1;
                  if (bitCnt_r == 3'd7) begin
                     ackPhaseNext_s = 1'b0;
                     if (state_r == ADDR) begin
                        if (rxByte_s[7:1] == SLAVE_ADDRESS) begin
                           stateNext_s = ADDR_ACK;
                           busyNext_s  = 1'b1;
                           rwNext_s    = rxByte_s[0];
                        end else begin
                           stateNext_s = IGNORE;
                        end
                     end else if (state_r == REG) begin
                        regAddrNext_s = rxByte_s;
                        stateNext_s   = REG_ACK;
                     end else begin
                        regWrDataNext_s = rxByte_s;
                        regWrEnNext_s   = 1'b1;
                        stateNext_s     = WR_ACK;
                     end
                  end else begin
                     stateNext_s = state_r;
                  end
               end else begin
                  stateNext_s = state_r;
               end
            end
            // First fall after the 8th bit starts the ACK, the second one ends it
            ADDR_ACK, REG_ACK, WR_ACK: begin
               if (sclFall_s) begin
                  if (!ackPhase_r) begin
                     sdaOutNext_s   = 1'b0;
                     ackPhaseNext_s = 1'b1;
                  end else begin
                     sdaOutNext_s   = 1'b1;
                     ackPhaseNext_s = 1'b0;
                     bitCntNext_s   = 3'd0;
                     case (state_r)
                        ADDR_ACK: begin
                           if (rw_r) begin
                              regRdEnNext_s = 1'b1;
                              txShiftNext_s = bus.regRdData[6:0];
                              sdaOutNext_s  = bus.regRdData[7];
                              stateNext_s   = RD;
                           end else begin
                              stateNext_s = REG;
                           end
                        end
                        REG_ACK: begin
                           stateNext_s = WR;
                        end
                        WR_ACK: begin
                           regAddrNext_s = regAddr_r + 8'd1;
                           stateNext_s   = WR;
                        end
                        default: begin
                           stateNext_s = IDLE;
                        end
                     endcase
                  end
               end else begin
                  stateNext_s = state_r;
               end
            end
            RD: begin
               if (sclRise_s) begin
                  bitCntNext_s = bitCnt_r + 3'd1;
                  if (bitCnt_r == 3'd7) begin
                     ackPhaseNext_s = 1'b0;
                     stateNext_s    = RD_ACK;
                  end else begin
                     stateNext_s = RD;
                  end
               end else if (sclFall_s) begin
                  sdaOutNext_s  = txShift_r[6];
                  txShiftNext_s = {txShift_r[5:0], 1'b0};
               end else begin
                  stateNext_s = RD;
               end
            end
            // Release after the 8th bit, sample controller ACK, then reload on the next fall
            RD_ACK: begin
               if (sclRise_s) begin
                  if (sdaNow_s) begin
                     stateNext_s = IGNORE;
                  end else begin
                     regAddrNext_s = regAddr_r + 8'd1;
                  end
               end else if (sclFall_s) begin
                  if (!ackPhase_r) begin
                     sdaOutNext_s   = 1'b1;
                     ackPhaseNext_s = 1'b1;
                  end else begin
                     regRdEnNext_s  = 1'b1;
                     txShiftNext_s  = bus.regRdData[6:0];
                     sdaOutNext_s   = bus.regRdData[7];
                     ackPhaseNext_s = 1'b0;
                     bitCntNext_s   = 3'd0;
                     stateNext_s    = RD;
                  end
               end else begin
                  stateNext_s = RD_ACK;
               end
            end
            default: begin
               stateNext_s  = IDLE;
               sdaOutNext_s = 1'b1;
            end
         endcase
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clockIn) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         bitCnt_r    <= 3'd0;
         rxShift_r   <= 7'd0;
         txShift_r   <= 7'd0;
         ackPhase_r  <= 1'b0;
         rw_r        <= 1'b0;
         sdaOut_r    <= 1'b1;
         regAddr_r   <= 8'h00;
         regWrData_r <= 8'h00;
         regWrEn_r   <= 1'b0;
         regRdEn_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= stateNext_s;
         bitCnt_r    <= bitCntNext_s;
         rxShift_r   <= rxShiftNext_s;
         txShift_r   <= txShiftNext_s;
         ackPhase_r  <= ackPhaseNext_s;
         rw_r        <= rwNext_s;
         sdaOut_r    <= sdaOutNext_s;
         regAddr_r   <= regAddrNext_s;
         regWrData_r <= regWrDataNext_s;
         regWrEn_r   <= regWrEnNext_s;
         regRdEn_r   <= regRdEnNext_s;
         busy_r      <= busyNext_s;
      end
   end

   assign bus.sdaOut    = sdaOut_r;
   assign bus.regAddr   = regAddr_r;
   assign bus.regWrData = regWrData_r;
   assign bus.regWrEn   = regWrEn_r;
   assign bus.regRdEn   = regRdEn_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Self-checking bench: a bit-banged I2C controller, combinational register file, and
// scoreboard queues of expected register-file strobes compared against recorded ones.
module tb_i2c_target_responder;

   logic clockIn = 1'b0;
   logic reset_n;
   logic sclCtl;
   logic sdaCtl;

   int   nRun;
   int   nFail;
   int   lowCnt;
   logic busySeen;

   logic [15:0] expWr[$];
   logic [15:0] obsWr[$];
   logic [7:0]  expRd[$];
   logic [7:0]  obsRd[$];

   i2c_target_responder_if bus();

   assign bus.sclIn     = sclCtl;
   assign bus.sdaIn     = sdaCtl & bus.sdaOut;
   assign bus.regRdData = bus.regAddr + 8'h40;

   i2c_target_responder #(.SLAVE_ADDRESS(7'h3C), .SYNC_STAGES(2)) dut (
      .clockIn (clockIn),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clockIn = ~clockIn;

   // One clock; sample just after the edge and record strobes / SDA drive
   task automatic tick();
      @(posedge clockIn);
      #1;
      if (bus.regWrEn === 1'b1) obsWr.push_back({bus.regAddr, bus.regWrData});
      if (bus.regRdEn === 1'b1) obsRd.push_back(bus.regAddr);
      if (bus.sdaOut === 1'b0) lowCnt++;
      if (bus.busy === 1'b1) busySeen = 1'b1;
   endtask

   task automatic quarter();
      repeat (10) tick();
   endtask

   task automatic i2cStart();
      sdaCtl = 1'b1; sclCtl = 1'b1; quarter();
      sdaCtl = 1'b0; quarter();
      sclCtl = 1'b0; quarter();
   endtask

   task automatic i2cRepStart();
      sdaCtl = 1'b1; quarter();
      sclCtl = 1'b1; quarter();
      sdaCtl = 1'b0; quarter();
      sclCtl = 1'b0; quarter();
   endtask

   task automatic i2cStop();
      sdaCtl = 1'b0; quarter();
      sclCtl = 1'b1; quarter();
      sdaCtl = 1'b1; quarter();
   endtask

   task automatic writeBit(input logic b);
      sdaCtl = b; quarter();
      sclCtl = 1'b1; quarter(); quarter();
      sclCtl = 1'b0; quarter();
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) writeBit(b[i]);
      sdaCtl = 1'b1; quarter();
      sclCtl = 1'b1; quarter();
      ack = bus.sdaIn; quarter();
      sclCtl = 1'b0; quarter();
   endtask

   task automatic readByte(output logic [7:0] d, input logic ctlAck);
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         sdaCtl = 1'b1; quarter();
         sclCtl = 1'b1; quarter();
         d = {d[6:0], bus.sdaIn}; quarter();
         sclCtl = 1'b0; quarter();
      end
      writeBit(~ctlAck);
   endtask

   task automatic clearObs();
      obsWr.delete();
      obsRd.delete();
      expWr.delete();
      expRd.delete();
      lowCnt   = 0;
      busySeen = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sclCtl = 1'b1; sdaCtl = 1'b1;
      repeat (5) tick();
      reset_n = 1'b1;
      clearObs();
      repeat (100) tick();
      nRun++;
      if (lowCnt !== 0) begin nFail++; $display("FAIL reset_sda: low cycles=%0d expected 0", lowCnt); end
      nRun++;
      if (busySeen !== 1'b0) begin nFail++; $display("FAIL reset_busy: busy seen=%b expected 0", busySeen); end
      nRun++;
      if (bus.regAddr !== 8'h00) begin nFail++; $display("FAIL reset_regaddr: got %h expected 00", bus.regAddr); end
      nRun++;
      if ((obsWr.size() + obsRd.size()) !== 0) begin
         nFail++; $display("FAIL reset_strobes: got %0d strobes expected 0", obsWr.size() + obsRd.size());
      end
   endtask

   task automatic test_single_write();
      logic a0, a1, a2, busyMid;
      logic [15:0] e, o;
      clearObs();
      expWr.push_back({8'h10, 8'hA5});
      i2cStart();
      writeByte(8'h78, a0);
      busyMid = bus.busy;
      writeByte(8'h10, a1);
      writeByte(8'hA5, a2);
      i2cStop();
      repeat (10) tick();
      nRun++;
      if ({a0, a1, a2} !== 3'b000) begin nFail++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
      nRun++;
      if (busyMid !== 1'b1) begin nFail++; $display("FAIL write_busy_mid: got %b expected 1", busyMid); end
      while (expWr.size() > 0) begin
         e = expWr.pop_front();
         nRun++;
         if (obsWr.size() == 0) begin
            nFail++; $display("FAIL write_strobe: got none expected addr/data %h", e);
         end else begin
            o = obsWr.pop_front();
            if (o !== e) begin nFail++; $display("FAIL write_strobe: got %h expected %h", o, e); end
         end
      end
      nRun++;
      if (obsWr.size() !== 0) begin nFail++; $display("FAIL write_extra: %0d extra strobes expected 0", obsWr.size()); end
      nRun++;
      if (bus.regAddr !== 8'h11) begin nFail++; $display("FAIL write_regaddr: got %h expected 11", bus.regAddr); end
      nRun++;
      if (bus.busy !== 1'b0) begin nFail++; $display("FAIL write_busy_end: got %b expected 0", bus.busy); end
   endtask

   task automatic test_burst_wrap();
      logic [3:0] acks;
      logic [15:0] e, o;
      clearObs();
      expWr.push_back({8'hFE, 8'h01});
      expWr.push_back({8'hFF, 8'h02});
      expWr.push_back({8'h00, 8'h03});
      i2cStart();
      writeByte(8'h78, acks[3]);
      writeByte(8'hFE, acks[2]);
      writeByte(8'h01, acks[1]);
      writeByte(8'h02, acks[0]);
      writeByte(8'h03, acks[0]);
      i2cStop();
      repeat (10) tick();
      nRun++;
      if (acks !== 4'b0000) begin nFail++; $display("FAIL burst_acks: got %b expected 0000", acks); end
      while (expWr.size() > 0) begin
         e = expWr.pop_front();
         nRun++;
         if (obsWr.size() == 0) begin
            nFail++; $display("FAIL burst_strobe: got none expected %h", e);
         end else begin
            o = obsWr.pop_front();
            if (o !== e) begin nFail++; $display("FAIL burst_strobe: got %h expected %h", o, e); end
         end
      end
      nRun++;
      if (obsWr.size() !== 0) begin nFail++; $display("FAIL burst_extra: %0d extra strobes expected 0", obsWr.size()); end
      nRun++;
      if (bus.regAddr !== 8'h01) begin nFail++; $display("FAIL burst_regaddr: got %h expected 01", bus.regAddr); end
   endtask

   task automatic test_read();
      logic a0, a1, a2;
      logic [7:0] d0, d1, e, o;
      logic busyPre, sdaRel;
      clearObs();
      expRd.push_back(8'h20);
      expRd.push_back(8'h21);
      i2cStart();
      writeByte(8'h78, a0);
      writeByte(8'h20, a1);
      i2cRepStart();
      writeByte(8'h79, a2);
      readByte(d0, 1'b1);
      readByte(d1, 1'b0);
      quarter();
      sdaRel  = bus.sdaOut;
      busyPre = bus.busy;
      i2cStop();
      repeat (10) tick();
      nRun++;
      if ({a0, a1, a2} !== 3'b000) begin nFail++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
      nRun++;
      if (d0 !== 8'h60) begin nFail++; $display("FAIL read_byte0: got %h expected 60", d0); end
      nRun++;
      if (d1 !== 8'h61) begin nFail++; $display("FAIL read_byte1: got %h expected 61", d1); end
      while (expRd.size() > 0) begin
         e = expRd.pop_front();
         nRun++;
         if (obsRd.size() == 0) begin
            nFail++; $display("FAIL read_strobe: got none expected regAddr %h", e);
         end else begin
            o = obsRd.pop_front();
            if (o !== e) begin nFail++; $display("FAIL read_strobe: got regAddr %h expected %h", o, e); end
         end
      end
      nRun++;
      if ((obsRd.size() + obsWr.size()) !== 0) begin
         nFail++; $display("FAIL read_extra: %0d extra strobes expected 0", obsRd.size() + obsWr.size());
      end
      nRun++;
      if (sdaRel !== 1'b1) begin nFail++; $display("FAIL read_release: sdaOut %b expected 1", sdaRel); end
      nRun++;
      if (busyPre !== 1'b1 || bus.busy !== 1'b0) begin
         nFail++; $display("FAIL read_busy: before/after stop %b%b expected 10", busyPre, bus.busy);
      end
      nRun++;
      if (bus.regAddr !== 8'h21) begin nFail++; $display("FAIL read_regaddr: got %h expected 21", bus.regAddr); end
   endtask

   task automatic test_mismatch();
      logic a0, a1, a2;
      clearObs();
      i2cStart();
      writeByte(8'h7A, a0);
      writeByte(8'h11, a1);
      writeByte(8'h22, a2);
      i2cStop();
      repeat (10) tick();
      nRun++;
      if (lowCnt !== 0) begin nFail++; $display("FAIL mismatch_sda: low cycles=%0d expected 0", lowCnt); end
      nRun++;
      if ({a0, a1, a2} !== 3'b111) begin nFail++; $display("FAIL mismatch_nack: got %b expected 111", {a0, a1, a2}); end
      nRun++;
      if (busySeen !== 1'b0) begin nFail++; $display("FAIL mismatch_busy: got %b expected 0", busySeen); end
      nRun++;
      if ((obsWr.size() + obsRd.size()) !== 0) begin
         nFail++; $display("FAIL mismatch_strobes: got %0d expected 0", obsWr.size() + obsRd.size());
      end
   endtask

   task automatic test_abort();
      logic a0, a1, a2;
      logic [7:0] addrRd;
      logic [15:0] e, o;
      clearObs();
      i2cStart();
      writeByte(8'h78, a0);
      writeByte(8'h30, a1);
      writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b0);
      i2cStop();
      repeat (10) tick();
      nRun++;
      if (obsWr.size() !== 0) begin nFail++; $display("FAIL partial_wr: got %0d strobes expected 0", obsWr.size()); end
      nRun++;
      if (bus.regAddr !== 8'h30 || bus.busy !== 1'b0) begin
         nFail++; $display("FAIL partial_state: regAddr %h busy %b expected 30 0", bus.regAddr, bus.busy);
      end

      clearObs();
      addrRd = 8'h79;
      i2cStart();
      writeByte(8'h78, a0);
      writeByte(8'h40, a1);
      i2cRepStart();
      for (int i = 7; i >= 0; i--) writeBit(addrRd[i]);
      sdaCtl = 1'b1; quarter();
      sclCtl = 1'b1; repeat (5) tick();
      nRun++;
      if (bus.sdaOut !== 1'b0) begin nFail++; $display("FAIL abort_ack_drive: sdaOut %b expected 0", bus.sdaOut); end
      reset_n = 1'b0;
      tick();
      nRun++;
      if (bus.sdaOut !== 1'b1 || bus.busy !== 1'b0 || bus.regAddr !== 8'h00) begin
         nFail++;
         $display("FAIL abort_reset: sdaOut %b busy %b regAddr %h expected 1 0 00", bus.sdaOut, bus.busy, bus.regAddr);
      end
      repeat (5) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      nRun++;
      if (obsRd.size() !== 0) begin nFail++; $display("FAIL abort_rd: got %0d strobes expected 0", obsRd.size()); end

      clearObs();
      expWr.push_back({8'h05, 8'h5A});
      i2cStart();
      writeByte(8'h78, a0);
      writeByte(8'h05, a1);
      writeByte(8'h5A, a2);
      i2cStop();
      repeat (10) tick();
      nRun++;
      if ({a0, a1, a2} !== 3'b000) begin nFail++; $display("FAIL recover_acks: got %b expected 000", {a0, a1, a2}); end
      while (expWr.size() > 0) begin
         e = expWr.pop_front();
         nRun++;
         if (obsWr.size() == 0) begin
            nFail++; $display("FAIL recover_strobe: got none expected %h", e);
         end else begin
            o = obsWr.pop_front();
            if (o !== e) begin nFail++; $display("FAIL recover_strobe: got %h expected %h", o, e); end
         end
      end
      nRun++;
      if (bus.regAddr !== 8'h06) begin nFail++; $display("FAIL recover_regaddr: got %h expected 06", bus.regAddr); end
   endtask

   initial begin
      nRun     = 0;
      nFail    = 0;
      lowCnt   = 0;
      busySeen = 1'b0;
      sclCtl   = 1'b1;
      sdaCtl   = 1'b1;
      reset_n  = 1'b0;
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_read();
      test_mismatch();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", nRun, nFail);
      $finish;
   end

endmodule
